// File: rtl/display_pkg.sv
// Shared constants and types for the binary-to-BCD display path.
package display_pkg;

  // Width of the binary input value.
  localparam int BIN_W = 14;
  // Width of the four-digit BCD scratch register.
  localparam int BCD_W = 16;
  // Width of the iteration counter (must hold ITER).
  localparam int CNT_W = 4;

  // Largest value that still fits in four decimal digits.
  localparam logic [BIN_W-1:0] BCD_MAX = 14'd9999;
  // One shift iteration per input bit.
  localparam logic [CNT_W-1:0] ITER = 4'd14;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // True when the value cannot be shown on four decimal digits.
  function automatic logic over_range(input logic [BIN_W-1:0] value);
    return (value > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Conditional add-3 on one nibble.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3).
// A conversion takes a fixed 15 cycles after start is accepted: 14 shift
// cycles followed by one cycle that publishes all four digits at once.
// Values above 9999 still run the full sequence but publish OVF_CODE on
// every digit and raise ovf.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter logic [3:0] OVF_CODE = 4'hE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       d3,
  output logic [3:0]       d2,
  output logic [3:0]       d1,
  output logic [3:0]       d0
);

  // Sequencer state.
  state_t state_r;
  state_t state_s;

  // Conversion datapath.
  logic [BIN_W-1:0]       shreg_r;
  logic [BCD_W-1:0]       scratch_r;
  logic [BCD_W-1:0]       scratch_adj_s;
  logic [BCD_W+BIN_W-1:0] shift_vec_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   ovf_pend_r;

  // Sequencer decisions for this cycle.
  logic accept_s;
  logic shift_en_s;
  logic load_en_s;

  // Registered outputs.
  logic       busy_r;
  logic       done_r;
  logic       ovf_r;
  logic [3:0] d3_r;
  logic [3:0] d2_r;
  logic [3:0] d1_r;
  logic [3:0] d0_r;

  // One add-3 corrector per BCD digit of the scratch register.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (scratch_r[4*g +: 4]),
        .dout (scratch_adj_s[4*g +: 4])
      );
    end
  endgenerate

  // Corrected scratch and remaining binary bits shifted left as one vector.
  assign shift_vec_s = {scratch_adj_s, shreg_r} << 1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    shift_en_s = 1'b0;
    load_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // The cycle showing done is IDLE too, but a start there is dropped
        // so a requester that saw done can rely on one clean gap.
        if (start && !done_r) begin
          state_s  = SHIFT;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        shift_en_s = 1'b1;
        // Leave after the shift that takes the counter to zero; the <=
        // also recovers if the counter were ever found at zero here.
        if (cnt_r <= 4'd1) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        load_en_s = 1'b1;
        state_s   = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Capture, shift and count for the conversion in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r    <= 14'd0;
      scratch_r  <= 16'd0;
      cnt_r      <= 4'd0;
      ovf_pend_r <= 1'b0;
    end else if (accept_s) begin
      shreg_r    <= bin;
      scratch_r  <= 16'd0;
      cnt_r      <= ITER;
      ovf_pend_r <= over_range(bin);
    end else if (shift_en_s) begin
      {scratch_r, shreg_r} <= shift_vec_s;
      cnt_r                <= cnt_r - 4'd1;
    end else begin
      shreg_r    <= shreg_r;
      scratch_r  <= scratch_r;
      cnt_r      <= cnt_r;
      ovf_pend_r <= ovf_pend_r;
    end
  end

  // Status flags: busy follows the state being entered, done marks the
  // cycle right after the digits were published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= load_en_s;
    end
  end

  // Publish all four digits and ovf together so the display never sees a
  // mix of old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      d3_r  <= 4'h0;
      d2_r  <= 4'h0;
      d1_r  <= 4'h0;
      d0_r  <= 4'h0;
    end else if (load_en_s) begin
      ovf_r <= ovf_pend_r;
      if (ovf_pend_r) begin
        d3_r <= OVF_CODE;
        d2_r <= OVF_CODE;
        d1_r <= OVF_CODE;
        d0_r <= OVF_CODE;
      end else begin
        d3_r <= scratch_r[15:12];
        d2_r <= scratch_r[11:8];
        d1_r <= scratch_r[7:4];
        d0_r <= scratch_r[3:0];
      end
    end else begin
      ovf_r <= ovf_r;
      d3_r  <= d3_r;
      d2_r  <= d2_r;
      d1_r  <= d1_r;
      d0_r  <= d0_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign ovf  = ovf_r;
  assign d3   = d3_r;
  assign d2   = d2_r;
  assign d1   = d1_r;
  assign d0   = d0_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a timing/decimal reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_bin_to_bcd_seq;

  localparam logic [3:0] OVF = 4'hE;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin   = 14'd0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  d3;
  logic [3:0]  d2;
  logic [3:0]  d1;
  logic [3:0]  d0;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: edge index and edge of the accepted start.
  int          e_idx    = 0;
  int          acc_edge = -1;
  logic [15:0] m_dig    = 16'h0;
  logic        m_ovf    = 1'b0;
  logic [15:0] exp_dig  = 16'h0;
  logic        exp_ovf  = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  bin_to_bcd_seq #(.OVF_CODE(OVF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0)
  );

  always #5 clk = ~clk;

  // Decimal split of a value, or the overflow code on every digit.
  function automatic logic [15:0] ref_digits(input int v);
    if (v > 9999) return {OVF, OVF, OVF, OVF};
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run one conversion; optionally pulse random starts while busy.
  task automatic go(input logic [13:0] val, input logic [15:0] lit_dig,
                    input logic lit_ovf, input bit lit, input bit noise);
    int lat;
    int busy_cnt;
    bit seen;
    start = 1'b1;
    bin   = val;
    @(posedge clk); #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    seen     = 1'b0;
    lat      = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (noise && i < 13 && $urandom_range(3, 0) == 0) begin
        start = 1'b1;
        bin   = 14'($urandom_range(16383, 0));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    start = 1'b0;
    if (!seen) $display("FAIL timeout: no done within 40 cycles for bin=%0d", val);
    chk("latency", lat, 15);
    if (lit) begin
      chk("busy_cycles", busy_cnt, 15);
      chk("digits", {d3, d2, d1, d0}, lit_dig);
      chk("ovf", ovf, lit_ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      // Reference model: fixed 15-cycle latency, starts ignored unless idle.
      begin : model
        forever begin
          @(posedge clk or negedge rst_n);
          if (!rst_n) begin
            e_idx = 0; acc_edge = -1; m_dig = 16'h0; m_ovf = 1'b0;
            exp_dig = 16'h0; exp_ovf = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
          end else begin
            e_idx++;
            if (acc_edge >= 0 && e_idx == acc_edge + 15) begin
              exp_dig = m_dig;
              exp_ovf = m_ovf;
            end
            if (start && (acc_edge < 0 || e_idx >= acc_edge + 17)) begin
              acc_edge = e_idx;
              m_dig    = ref_digits(int'(bin));
              m_ovf    = (int'(bin) > 9999);
            end
            exp_done = (acc_edge >= 0 && e_idx == acc_edge + 15);
            exp_busy = (acc_edge >= 0 && e_idx <= acc_edge + 14);
          end
        end
      end
      // Per-cycle comparison of every output against the model.
      begin : compare
        forever begin
          @(posedge clk); #2;
          chk("cycle", {busy, done, ovf, d3, d2, d1, d0},
              {exp_busy, exp_done, exp_ovf, exp_dig});
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, ovf, d3, d2, d1, d0}, 19'h0);
    rst_n = 1'b1;

    // Basic conversion and back-to-back extremes.
    go(14'd1234, 16'h1234, 1'b0, 1'b1, 1'b0);
    go(14'd0,    16'h0000, 1'b0, 1'b1, 1'b0);
    go(14'd9999, 16'h9999, 1'b0, 1'b1, 1'b0);
    go(14'd10000, 16'hEEEE, 1'b1, 1'b1, 1'b0);
    go(14'd42,   16'h0042, 1'b0, 1'b1, 1'b0);

    // Start pulsed while busy is not queued.
    begin
      int dn;
      start = 1'b1; bin = 14'd5678;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; bin = 14'd1;
      @(posedge clk); #1;
      start = 1'b0;
      dn = 0;
      for (int i = 0; i < 35; i++) begin
        @(posedge clk); #1;
        if (done) dn++;
      end
      chk("busy_start_done_count", dn, 1);
      chk("busy_start_digits", {d3, d2, d1, d0}, 16'h5678);
    end

    // Start in the done cycle is ignored.
    begin
      int dn;
      start = 1'b1; bin = 14'd321;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("done_cycle_pulse", done, 1'b1);
      start = 1'b1; bin = 14'd999;
      @(posedge clk); #1;
      start = 1'b0;
      dn = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done || busy) dn++;
      end
      chk("done_cycle_start_ignored", dn, 0);
      chk("done_cycle_digits", {d3, d2, d1, d0}, 16'h0321);
    end

    // Reset mid-conversion aborts; first cycle after release accepts.
    start = 1'b1; bin = 14'd4321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, ovf, d3, d2, d1, d0}, 19'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    go(14'd16383, 16'hEEEE, 1'b1, 1'b1, 1'b0);

    // Randomized conversions with stray starts while busy.
    for (int n = 0; n < 1000; n++) begin
      go(14'($urandom_range(16383, 0)), 16'h0, 1'b0, 1'b0, 1'b1);
    end

    repeat (2) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
